// File: rtl/cordic_controller_if.sv
// Control bundle between cordic_controller (master) and its requester/datapath (slave).
// CORDIC_CTRL_ABORT_EN adds the abort_i request line.
`timescale 1ns/1ps
interface cordic_controller_if;
  logic       start_i;
  logic       valid_i;
`ifdef CORDIC_CTRL_ABORT_EN
  logic       abort_i;
`endif
  logic       busy_o;
  logic       done_o;
  logic       start_o;
  logic       check_for_termination_o;
  logic [2:0] mode_o;
  logic       wren_x_n_o;
  logic       wren_y_n_o;
  logic       wren_phi_sum_o;
  logic       wren_sigma_n_o;
  logic       wren_x_0_o;
  logic       wren_y_0_o;
  logic       x_0_to_alu_a_o;
  logic       y_0_to_alu_a_o;
  logic       edb_to_alu_a_o;
  logic       one_to_alu_a_o;
  logic       x_0_to_alu_b_o;
  logic       y_0_to_alu_b_o;
  logic       n_to_alu_b_o;
  logic       sigma_n_to_alu_b_o;
  logic       phi_sum_to_alu_b_o;
  logic       phi_to_alu_b_o;

  modport master (
`ifdef CORDIC_CTRL_ABORT_EN
    input  abort_i,
`endif
    input  start_i, valid_i,
    output busy_o, done_o, start_o, check_for_termination_o, mode_o,
    output wren_x_n_o, wren_y_n_o, wren_phi_sum_o, wren_sigma_n_o, wren_x_0_o, wren_y_0_o,
    output x_0_to_alu_a_o, y_0_to_alu_a_o, edb_to_alu_a_o, one_to_alu_a_o,
    output x_0_to_alu_b_o, y_0_to_alu_b_o, n_to_alu_b_o, sigma_n_to_alu_b_o,
    output phi_sum_to_alu_b_o, phi_to_alu_b_o
  );

  modport slave (
`ifdef CORDIC_CTRL_ABORT_EN
    output abort_i,
`endif
    output start_i, valid_i,
    input  busy_o, done_o, start_o, check_for_termination_o, mode_o,
    input  wren_x_n_o, wren_y_n_o, wren_phi_sum_o, wren_sigma_n_o, wren_x_0_o, wren_y_0_o,
    input  x_0_to_alu_a_o, y_0_to_alu_a_o, edb_to_alu_a_o, one_to_alu_a_o,
    input  x_0_to_alu_b_o, y_0_to_alu_b_o, n_to_alu_b_o, sigma_n_to_alu_b_o,
    input  phi_sum_to_alu_b_o, phi_to_alu_b_o
  );
endinterface

// File: rtl/cordic_controller.sv
// Moore sequencer for cordic_datapath: WAIT, then S0..S8 per rotation iteration, then DONE.
// Define CORDIC_CTRL_ABORT_EN to add abort_i (returns to IDLE from any busy state).
`timescale 1ns/1ps
module cordic_controller (
  input logic                 clk,
  input logic                 rst,
  cordic_controller_if.master bus
);
  localparam int unsigned STATE_W = 4;
  localparam int unsigned MODE_W  = 3;

  localparam logic [STATE_W-1:0] IDLE = 4'd0;
  localparam logic [STATE_W-1:0] WAIT = 4'd1;
  localparam logic [STATE_W-1:0] S0   = 4'd2;
  localparam logic [STATE_W-1:0] S1   = 4'd3;
  localparam logic [STATE_W-1:0] S2   = 4'd4;
  localparam logic [STATE_W-1:0] S3   = 4'd5;
  localparam logic [STATE_W-1:0] S4   = 4'd6;
  localparam logic [STATE_W-1:0] S5   = 4'd7;
  localparam logic [STATE_W-1:0] S6   = 4'd8;
  localparam logic [STATE_W-1:0] S7   = 4'd9;
  localparam logic [STATE_W-1:0] S8   = 4'd10;
  localparam logic [STATE_W-1:0] DONE = 4'd11;

  localparam logic [MODE_W-1:0] MODE_ADD   = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHR   = 3'd1;
  localparam logic [MODE_W-1:0] MODE_XUPD  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_YUPD  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_SGNA  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_BADDC = 3'd5;
  localparam logic [MODE_W-1:0] MODE_BSUBC = 3'd6;

  logic [STATE_W-1:0] state, next_state;
  logic               abort;

`ifdef CORDIC_CTRL_ABORT_EN
  assign abort = bus.abort_i;
`else
  assign abort = 1'b0;
`endif

  // Registered control outputs; *_d is the decode of next_state so *_q tracks state.
  logic              busy_d, done_d, check_d;
  logic [MODE_W-1:0] mode_d;
  logic              wr_xn_d, wr_yn_d, wr_phi_d, wr_sig_d, wr_x0_d, wr_y0_d;
  logic              a_x0_d, a_y0_d, a_edb_d, a_one_d;
  logic              b_x0_d, b_y0_d, b_n_d, b_sig_d, b_phisum_d, b_phi_d;

  logic              busy_q, done_q, check_q;
  logic [MODE_W-1:0] mode_q;
  logic              wr_xn_q, wr_yn_q, wr_phi_q, wr_sig_q, wr_x0_q, wr_y0_q;
  logic              a_x0_q, a_y0_q, a_edb_q, a_one_q;
  logic              b_x0_q, b_y0_q, b_n_q, b_sig_q, b_phisum_q, b_phi_q;

  // Next-state and output decode
  always_comb begin
    next_state = IDLE;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    check_d    = 1'b0;
    mode_d     = MODE_ADD;
    wr_xn_d    = 1'b0;
    wr_yn_d    = 1'b0;
    wr_phi_d   = 1'b0;
    wr_sig_d   = 1'b0;
    wr_x0_d    = 1'b0;
    wr_y0_d    = 1'b0;
    a_x0_d     = 1'b0;
    a_y0_d     = 1'b0;
    a_edb_d    = 1'b0;
    a_one_d    = 1'b0;
    b_x0_d     = 1'b0;
    b_y0_d     = 1'b0;
    b_n_d      = 1'b0;
    b_sig_d    = 1'b0;
    b_phisum_d = 1'b0;
    b_phi_d    = 1'b0;

    case (state)
      IDLE:                           next_state = bus.start_i ? WAIT : IDLE;
      WAIT:                           next_state = S0;
      S0, S1, S2, S3, S4, S5, S6, S7: next_state = STATE_W'(state + 4'd1);
      S8:                             next_state = bus.valid_i ? DONE : S0;
      DONE:                           next_state = IDLE;
      default:                        next_state = IDLE;
    endcase
    if (abort && (state != IDLE)) next_state = IDLE;

    busy_d  = (next_state != IDLE) && (next_state != DONE);
    done_d  = (next_state == DONE);
    check_d = (next_state == S8);

    // Write enables trail their operand selects by one state (registered ALU result)
    case (next_state)
      S0: begin a_y0_d = 1'b1; b_n_d = 1'b1; mode_d = MODE_SHR; end
      S1: begin a_x0_d = 1'b1; b_sig_d = 1'b1; mode_d = MODE_XUPD; end
      S2: begin wr_xn_d = 1'b1; a_x0_d = 1'b1; b_n_d = 1'b1; mode_d = MODE_SHR; end
      S3: begin a_y0_d = 1'b1; b_sig_d = 1'b1; mode_d = MODE_YUPD; end
      S4: begin wr_yn_d = 1'b1; a_edb_d = 1'b1; b_sig_d = 1'b1; mode_d = MODE_SGNA; end
      S5: begin b_phisum_d = 1'b1; mode_d = MODE_BADDC; end
      S6: begin wr_phi_d = 1'b1; b_phi_d = 1'b1; mode_d = MODE_BSUBC; end
      S7: begin
        wr_sig_d = 1'b1; wr_x0_d = 1'b1; wr_y0_d = 1'b1;
        a_one_d  = 1'b1; b_n_d = 1'b1; mode_d = MODE_ADD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      check_q    <= 1'b0;
      mode_q     <= MODE_ADD;
      wr_xn_q    <= 1'b0;
      wr_yn_q    <= 1'b0;
      wr_phi_q   <= 1'b0;
      wr_sig_q   <= 1'b0;
      wr_x0_q    <= 1'b0;
      wr_y0_q    <= 1'b0;
      a_x0_q     <= 1'b0;
      a_y0_q     <= 1'b0;
      a_edb_q    <= 1'b0;
      a_one_q    <= 1'b0;
      b_x0_q     <= 1'b0;
      b_y0_q     <= 1'b0;
      b_n_q      <= 1'b0;
      b_sig_q    <= 1'b0;
      b_phisum_q <= 1'b0;
      b_phi_q    <= 1'b0;
    end else begin
      state      <= next_state;
      busy_q     <= busy_d;
      done_q     <= done_d;
      check_q    <= check_d;
      mode_q     <= mode_d;
      wr_xn_q    <= wr_xn_d;
      wr_yn_q    <= wr_yn_d;
      wr_phi_q   <= wr_phi_d;
      wr_sig_q   <= wr_sig_d;
      wr_x0_q    <= wr_x0_d;
      wr_y0_q    <= wr_y0_d;
      a_x0_q     <= a_x0_d;
      a_y0_q     <= a_y0_d;
      a_edb_q    <= a_edb_d;
      a_one_q    <= a_one_d;
      b_x0_q     <= b_x0_d;
      b_y0_q     <= b_y0_d;
      b_n_q      <= b_n_d;
      b_sig_q    <= b_sig_d;
      b_phisum_q <= b_phisum_d;
      b_phi_q    <= b_phi_d;
    end
  end

  // start_o alone is combinational so the datapath sees the request in the accepting cycle
  assign bus.start_o                 = (state == IDLE) && bus.start_i;
  assign bus.busy_o                  = busy_q;
  assign bus.done_o                  = done_q;
  assign bus.check_for_termination_o = check_q;
  assign bus.mode_o                  = mode_q;
  assign bus.wren_x_n_o              = wr_xn_q;
  assign bus.wren_y_n_o              = wr_yn_q;
  assign bus.wren_phi_sum_o          = wr_phi_q;
  assign bus.wren_sigma_n_o          = wr_sig_q;
  assign bus.wren_x_0_o              = wr_x0_q;
  assign bus.wren_y_0_o              = wr_y0_q;
  assign bus.x_0_to_alu_a_o          = a_x0_q;
  assign bus.y_0_to_alu_a_o          = a_y0_q;
  assign bus.edb_to_alu_a_o          = a_edb_q;
  assign bus.one_to_alu_a_o          = a_one_q;
  assign bus.x_0_to_alu_b_o          = b_x0_q;
  assign bus.y_0_to_alu_b_o          = b_y0_q;
  assign bus.n_to_alu_b_o            = b_n_q;
  assign bus.sigma_n_to_alu_b_o      = b_sig_q;
  assign bus.phi_sum_to_alu_b_o      = b_phisum_q;
  assign bus.phi_to_alu_b_o          = b_phi_q;
endmodule

// File: tb/tb_cordic_controller.sv
// Self-checking bench for cordic_controller: cycle-offset timeline model of each run.
// Build with CORDIC_CTRL_ABORT_EN to also exercise abort_i.
`timescale 1ns/1ps
module tb_cordic_controller;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cordic_controller_if bus ();
  cordic_controller dut (.clk(clk), .rst(rst), .bus(bus));

  // {busy, done, start, check, mode[2:0], wren x_n,y_n,phi_sum,sigma_n,x_0,y_0,
  //  A x_0,y_0,edb,one, B x_0,y_0,n,sigma,phi_sum,phi}
  function automatic logic [22:0] observed();
    return {bus.busy_o, bus.done_o, bus.start_o, bus.check_for_termination_o, bus.mode_o,
            bus.wren_x_n_o, bus.wren_y_n_o, bus.wren_phi_sum_o, bus.wren_sigma_n_o,
            bus.wren_x_0_o, bus.wren_y_0_o,
            bus.x_0_to_alu_a_o, bus.y_0_to_alu_a_o, bus.edb_to_alu_a_o, bus.one_to_alu_a_o,
            bus.x_0_to_alu_b_o, bus.y_0_to_alu_b_o, bus.n_to_alu_b_o, bus.sigma_n_to_alu_b_o,
            bus.phi_sum_to_alu_b_o, bus.phi_to_alu_b_o};
  endfunction

  // Expected outputs k cycles after the start was accepted, for a run of n_it iterations
  function automatic logic [22:0] expected(int k, int n_it, logic st);
    logic       busy, done, start, chk;
    logic [2:0] mode;
    logic [5:0] wr;
    logic [3:0] a;
    logic [5:0] b;
    int         p;
    busy = 0; done = 0; start = 0; chk = 0; mode = 3'd0; wr = '0; a = '0; b = '0;
    if (k == 0) start = st;
    else if (k == 1) busy = 1;
    else if (k < 2 + 9 * n_it) begin
      busy = 1;
      p = (k - 2) % 9;
      case (p)
        0: begin a = 4'b0100; b = 6'b001000; mode = 3'd1; end
        1: begin a = 4'b1000; b = 6'b000100; mode = 3'd2; end
        2: begin wr = 6'b100000; a = 4'b1000; b = 6'b001000; mode = 3'd1; end
        3: begin a = 4'b0100; b = 6'b000100; mode = 3'd3; end
        4: begin wr = 6'b010000; a = 4'b0010; b = 6'b000100; mode = 3'd4; end
        5: begin b = 6'b000010; mode = 3'd5; end
        6: begin wr = 6'b001000; b = 6'b000001; mode = 3'd6; end
        7: begin wr = 6'b000111; a = 4'b0001; b = 6'b001000; mode = 3'd0; end
        default: chk = 1;
      endcase
    end else if (k == 2 + 9 * n_it) done = 1;
    return {busy, done, start, chk, mode, wr, a, b};
  endfunction

  function automatic int iters(int num_it);
    return (num_it == 0) ? 8 : num_it;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(string name, int k, logic [22:0] exp_v);
    logic [22:0] got;
    @(negedge clk);
    got = observed();
    n_tests++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h expected=%h", name, k, got, exp_v);
    end
  endtask

  // Drive one run of num_it from IDLE; checks every cycle up to and including done_o
  task automatic run(string name, int num_it, bit hold, bit noise, int stop_k);
    int  n, last, p, it;
    n    = iters(num_it);
    last = 2 + 9 * n;
    for (int k = 0; k <= last; k++) begin
      bus.start_i = hold ? 1'b1 : (k == 0);
      bus.valid_i = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      if (k >= 2 && k < last) begin
        p  = (k - 2) % 9;
        it = (k - 2) / 9;
        if (p == 8) bus.valid_i = (it == n - 1);
      end
      check_vec(name, k, expected(k, n, bus.start_i));
      if (k == stop_k) return;
      next_cycle();
    end
    bus.valid_i = 1'b0;
    if (hold) begin
      check_vec({name, "_restart"}, last + 1, 23'h100000);
      bus.start_i = 1'b0;
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
    end else begin
      bus.start_i = 1'b0;
      next_cycle();
      check_vec({name, "_idle"}, last + 1, 23'h0);
      next_cycle();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.valid_i = 1'b0;
`ifdef CORDIC_CTRL_ABORT_EN
    bus.abort_i = 1'b0;
`endif
    next_cycle();
    next_cycle();
    check_vec("reset", 0, 23'h0);
    rst = 1'b0;
    next_cycle();
    check_vec("reset_idle", 1, 23'h0);
    next_cycle();
  endtask

  task automatic test_single_iteration();
    run("numit1", 1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_wrap_numit0();
    run("numit0", 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_held();
    run("held", 3, 1'b1, 1'b0, -1);
    check_vec("held_after_rst", 0, 23'h0);
    next_cycle();
  endtask

  task automatic test_valid_noise();
    for (int i = 0; i < 6; i++) run("noise", int'($urandom_range(7, 0)), 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_run();
    run("mid_rst", 2, 1'b0, 1'b0, 5);
    rst = 1'b1;
    bus.start_i = 1'b0;
    next_cycle();
    rst = 1'b0;
    check_vec("mid_rst_clear", 6, 23'h0);
    next_cycle();
    run("after_rst", int'($urandom_range(7, 1)), 1'b0, 1'b1, -1);
  endtask

`ifdef CORDIC_CTRL_ABORT_EN
  task automatic test_abort();
    run("abort", 3, 1'b0, 1'b0, 16);
    bus.abort_i = 1'b1;
    bus.start_i = 1'b0;
    next_cycle();
    bus.abort_i = 1'b0;
    for (int k = 17; k < 24; k++) begin
      check_vec("abort_idle", k, 23'h0);
      next_cycle();
    end
    run("after_abort", 1, 1'b0, 1'b0, -1);
  endtask
`endif

  initial begin
    test_reset();
    test_single_iteration();
    test_wrap_numit0();
    test_start_held();
    test_valid_noise();
    test_reset_mid_run();
`ifdef CORDIC_CTRL_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
